inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
- Converts the fetch stage's SRAM-like instruction port (req/addr_ok/data_ok) into a read-only AXI4 master (AR and R channels).
- Sits directly upstream of the fetch stage, between it and the top-level AXI crossbar.
- Supports up to MAX_OUT in-order outstanding single-beat reads, all issued with one fixed ARID.
- The fetch stage tracks its own outstanding count from addr_ok/data_ok; this block must never reorder, drop or duplicate responses.

Parameters:
- ARID, 4'd0: constant ID driven on arid.
- MAX_OUT, 4: maximum accepted-but-unreturned requests (1..7).
- R_REG, 0: 0 = R channel passed combinationally to data_ok/rdata; 1 = R beat registered, data_ok one cycle after the R handshake.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_sram_req  in  1  fetch request
- inst_sram_wr  in  1  ignored; the port is read-only
- inst_sram_size  in  2  log2 bytes; 2 = word
- inst_sram_addr  in  32  fetch address
- inst_sram_wstrb  in  4  ignored
- inst_sram_wdata  in  32  ignored
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  read data valid this cycle
- inst_sram_rdata  out  32  read data
- arid  out  4  = ARID
- araddr  out  32  read address
- arlen  out  8  = 0
- arsize  out  3  = {1'b0, size}
- arburst  out  2  = 2'b01
- arlock  out  2  = 0
- arcache  out  4  = 0
- arprot  out  3  = 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  ignored (single beat)
- rvalid  in  1  R valid
- rready  out  1  R ready
- rresp_err  out  1  sticky: some R beat carried rresp != 0

Behaviour:
- Reset (synchronous): arvalid=0, araddr=0, arsize=0, outstanding count cnt=0, rready=0, data_ok=0, rdata=0, rresp_err=0, R_REG holding register empty.
- AR FSM, two states:
  - IDLE: addr_ok = req & (cnt_total < MAX_OUT), where cnt_total = cnt plus any request held in the AR register. On addr_ok, latch addr and size, go to SEND; arvalid=1 from the next cycle.
  - SEND: arvalid=1. araddr and arsize stay stable until arready. On arvalid & arready, return to IDLE.
  - addr_ok is forced 0 in SEND, so at most one new request is accepted per AR handshake. Minimum issue interval: 2 cycles.
- Counter: cnt increments on addr_ok and decrements on data_ok. Both in the same cycle leaves cnt unchanged. Width 3 bits; must never exceed MAX_OUT and must never underflow.
- rready = (cnt != 0) when R_REG=0. The fetch stage cannot stall data_ok, so responses are always accepted while outstanding.
- Stray rvalid while cnt == 0: rready=0, the beat is not accepted, and no data_ok is produced.
- R_REG=0: data_ok = rvalid & rready; inst_sram_rdata = rdata, combinational.
- R_REG=1:
  - On rvalid & rready, capture rdata; data_ok=1 in the next cycle with the captured data.
  - rready = (cnt != 0) & ~(holding register full & ~data_ok); the register drains every cycle.
  - cnt decrements on data_ok, not on the R handshake.
- Response order equals request order (single ARID); no tagging required.
- rresp_err: set on any accepted beat with rresp != 0, cleared only by reset. Data is still returned with data_ok.
- The wr, wstrb and wdata inputs have no effect.
- Reset mid-transaction clears all state. The AXI slave is reset by the same reset, so no response draining is performed.

Test Plan:
- Single fetch, addr 0x1c000000, arready=1, rvalid 2 cycles after AR, rdata=0x02800000 → addr_ok at cycle 0; arvalid=1 at cycle 1 with araddr=0x1c000000, arsize=3'b010, arlen=0; data_ok=1 with inst_sram_rdata=0x02800000 in the rvalid cycle (R_REG=0).
- req held high, arready=1, responses withheld → exactly 4 addr_ok pulses (MAX_OUT=4), then addr_ok stays 0. After one R beat, cnt=3 and one more addr_ok is issued.
- arready held low 5 cycles with araddr=0x1c000010 → arvalid and araddr stable across all 5 cycles; addr_ok=0 throughout; AR handshake in cycle 6.
- addr_ok and data_ok coincide with cnt=2 → cnt remains 2. Stray rvalid with cnt=0 → rready=0, data_ok=0.
- rresp=2'b10 on the second of three reads → rresp_err rises the cycle after that beat and stays 1. All 3 data_ok pulses occur. Reset → rresp_err=0, cnt=0, arvalid=0.
- R_REG=1, back-to-back R beats 0xAAAA0000, 0xBBBB0000 → data_ok on the 2 cycles following each handshake, in order; cnt reaches 0 after the second data_ok.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// Bridges the fetch stage's SRAM-like instruction port onto a read-only AXI4 master.
// Single-beat, in-order reads on one fixed ARID, with up to MAX_OUT requests in flight.
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID    = 4'd0,
  parameter int         MAX_OUT = 4,
  parameter int         R_REG   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rresp_err
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  state_t     state;
  logic [2:0] cnt;
  logic       r_hs;
  logic       unused;

  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  // The request waiting in the AR register was counted in cnt when accepted,
  // and nothing is ever accepted in SEND, so cnt alone bounds the total.
  assign inst_sram_addr_ok = (state == IDLE) & inst_sram_req & (cnt < MAX_CNT);
  assign r_hs              = rvalid & rready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
    end else begin
      case (state)
        IDLE: if (inst_sram_addr_ok) begin
          state   <= SEND;
          arvalid <= 1'b1;
          araddr  <= inst_sram_addr;
          arsize  <= {1'b0, inst_sram_size};
        end
        SEND: if (arready) begin
          state   <= IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 3'd0;
    end else begin
      case ({inst_sram_addr_ok, inst_sram_data_ok})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                    rresp_err <= 1'b0;
    else if (r_hs && rresp != 2'b00) rresp_err <= 1'b1;
  end

  generate
    if (R_REG != 0) begin : g_rreg
      logic        hold_full;
      logic [31:0] hold_data;

      // The holding register drains every cycle, so it never blocks a new beat
      // in practice; the guard keeps that true if the drain ever becomes stallable.
      assign rready            = (cnt != 3'd0) & ~(hold_full & ~inst_sram_data_ok);
      assign inst_sram_data_ok = hold_full;
      assign inst_sram_rdata   = hold_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          hold_full <= 1'b0;
          hold_data <= 32'd0;
        end else begin
          hold_full <= r_hs;
          if (r_hs) hold_data <= rdata;
        end
      end
    end else begin : g_rcomb
      assign rready            = (cnt != 3'd0);
      assign inst_sram_data_ok = r_hs;
      assign inst_sram_rdata   = rdata;
    end
  endgenerate

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: a vector table for the basic fetch and AR stall,
// plus hand sequences for outstanding limits, counter corners, error flag and R_REG=1.
module tb_inst_axi_rd_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // dut0: R_REG=0, dut1: R_REG=1
  logic        req0, arready0, rvalid0;
  logic [31:0] addr0, rdata0;
  logic [1:0]  rresp0;
  logic        addr_ok0, data_ok0, arvalid0, rready0, err0;
  logic [31:0] srdata0, araddr0;
  logic [3:0]  arid0, arcache0;
  logic [7:0]  arlen0;
  logic [2:0]  arsize0, arprot0;
  logic [1:0]  arburst0, arlock0;

  logic        req1, arready1, rvalid1;
  logic [31:0] addr1, rdata1;
  logic [1:0]  rresp1;
  logic        addr_ok1, data_ok1, arvalid1, rready1, err1;
  logic [31:0] srdata1, araddr1;
  logic [3:0]  arid1, arcache1;
  logic [7:0]  arlen1;
  logic [2:0]  arsize1, arprot1;
  logic [1:0]  arburst1, arlock1;

  inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUT(4), .R_REG(0)) dut0 (
    .clk(clk), .reset(reset),
    .inst_sram_req(req0), .inst_sram_wr(1'b1), .inst_sram_size(2'd2),
    .inst_sram_addr(addr0), .inst_sram_wstrb(4'hf), .inst_sram_wdata(32'hffff_ffff),
    .inst_sram_addr_ok(addr_ok0), .inst_sram_data_ok(data_ok0), .inst_sram_rdata(srdata0),
    .arid(arid0), .araddr(araddr0), .arlen(arlen0), .arsize(arsize0), .arburst(arburst0),
    .arlock(arlock0), .arcache(arcache0), .arprot(arprot0), .arvalid(arvalid0),
    .arready(arready0), .rid(4'd5), .rdata(rdata0), .rresp(rresp0), .rlast(1'b1),
    .rvalid(rvalid0), .rready(rready0), .rresp_err(err0)
  );

  inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUT(4), .R_REG(1)) dut1 (
    .clk(clk), .reset(reset),
    .inst_sram_req(req1), .inst_sram_wr(1'b0), .inst_sram_size(2'd2),
    .inst_sram_addr(addr1), .inst_sram_wstrb(4'h0), .inst_sram_wdata(32'd0),
    .inst_sram_addr_ok(addr_ok1), .inst_sram_data_ok(data_ok1), .inst_sram_rdata(srdata1),
    .arid(arid1), .araddr(araddr1), .arlen(arlen1), .arsize(arsize1), .arburst(arburst1),
    .arlock(arlock1), .arcache(arcache1), .arprot(arprot1), .arvalid(arvalid1),
    .arready(arready1), .rid(4'd0), .rdata(rdata1), .rresp(rresp1), .rlast(1'b1),
    .rvalid(rvalid1), .rready(rready1), .rresp_err(err1)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] srdata;
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive0(input logic rq, input logic [31:0] ad, input logic ardy,
                        input logic rv, input logic [31:0] rd, input logic [1:0] rr);
    @(negedge clk);
    req0 = rq; addr0 = ad; arready0 = ardy; rvalid0 = rv; rdata0 = rd; rresp0 = rr;
    #1;
  endtask

  task automatic drive1(input logic rq, input logic [31:0] ad, input logic ardy,
                        input logic rv, input logic [31:0] rd);
    @(negedge clk);
    req1 = rq; addr1 = ad; arready1 = ardy; rvalid1 = rv; rdata1 = rd; rresp1 = 2'b00;
    #1;
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1, 32'h1c00_0000, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0000, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 32'h1c00_0000, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0280_0000, 2'b00, 1'b0, 1'b1, 32'h0280_0000, 1'b0, 32'h1c00_0000, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 32'h1c00_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h1c00_0010, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0,          1'b0, 32'h1c00_0000, 1'b0};
    for (int i = 6; i <= 10; i++)
      vecs[i] = '{1'b1, 32'h1c00_0020, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1c00_0010, 1'b1};
    vecs[11] = '{1'b1, 32'h1c00_0020, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0010, 1'b1};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h1111_1111, 2'b00, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h1c00_0010, 1'b1};

    reset = 1'b1;
    req0 = 0; addr0 = 0; arready0 = 0; rvalid0 = 0; rdata0 = 0; rresp0 = 0;
    req1 = 0; addr1 = 0; arready1 = 0; rvalid1 = 0; rdata1 = 0; rresp1 = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_arvalid", arvalid0, 0);
    check("rst_araddr", araddr0, 0);
    check("rst_arsize", arsize0, 0);
    check("rst_rready", rready0, 0);
    check("rst_err", err0, 0);
    check("rst_r1_data_ok", data_ok1, 0);
    check("rst_r1_rdata", srdata1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single fetch and a 5-cycle AR stall, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      drive0(vecs[i].req, vecs[i].addr, vecs[i].arready, vecs[i].rvalid, vecs[i].rdata, vecs[i].rresp);
      check($sformatf("v%0d_addr_ok", i), addr_ok0, vecs[i].addr_ok);
      check($sformatf("v%0d_data_ok", i), data_ok0, vecs[i].data_ok);
      check($sformatf("v%0d_arvalid", i), arvalid0, vecs[i].arvalid);
      check($sformatf("v%0d_araddr", i), araddr0, vecs[i].araddr);
      check($sformatf("v%0d_rready", i), rready0, vecs[i].rready);
      if (vecs[i].data_ok) check($sformatf("v%0d_rdata", i), srdata0, vecs[i].srdata);
    end
    check("arsize_word", arsize0, 3'b010);
    check("arlen", arlen0, 0);
    check("arburst", arburst0, 2'b01);
    check("arid", arid0, 0);

    // Outstanding limit: req held, responses withheld
    n = 0;
    for (int i = 0; i < 14; i++) begin
      drive0(1'b1, 32'h1c00_0100 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 2'b00);
      if (addr_ok0) n++;
    end
    check("max_out_pulses", n, 4);
    check("max_out_cnt", dut0.cnt, 4);
    drive0(1'b1, 32'h1c00_0200, 1'b1, 1'b1, 32'h1234_5678, 2'b00);
    check("max_out_full_addr_ok", addr_ok0, 0);
    check("max_out_beat_data_ok", data_ok0, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, 32'h1c00_0300, 1'b1, 1'b0, 32'h0, 2'b00);
      if (addr_ok0) n++;
    end
    check("refill_pulses", n, 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b0, 32'h0, 1'b1, 1'b1, 32'(i), 2'b00);
      if (data_ok0) n++;
    end
    check("drain_data_ok", n, 4);
    drive0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
    check("drain_rready", rready0, 0);
    check("drain_cnt", dut0.cnt, 0);

    // addr_ok and data_ok together at cnt=2
    drive0(1'b1, 32'h1c00_0400, 1'b1, 1'b0, 32'h0, 2'b00);
    drive0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
    drive0(1'b1, 32'h1c00_0404, 1'b1, 1'b0, 32'h0, 2'b00);
    drive0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
    check("coin_pre_cnt", dut0.cnt, 2);
    drive0(1'b1, 32'h1c00_0408, 1'b1, 1'b1, 32'hcafe_0001, 2'b00);
    check("coin_addr_ok", addr_ok0, 1);
    check("coin_data_ok", data_ok0, 1);
    drive0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
    check("coin_post_cnt", dut0.cnt, 2);
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'hcafe_0002, 2'b00);
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'hcafe_0003, 2'b00);
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
    check("coin_drain_cnt", dut0.cnt, 0);

    // Stray R beat with nothing outstanding
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'hdead_beef, 2'b00);
    check("stray_rready", rready0, 0);
    check("stray_data_ok", data_ok0, 0);
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
    check("stray_cnt", dut0.cnt, 0);

    // SLVERR on the second of three reads
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 32'h1c00_0500 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 2'b00);
      drive0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
    end
    n = 0;
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0a01, 2'b00);
    if (data_ok0) n++;
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0a02, 2'b10);
    if (data_ok0) n++;
    check("err_same_cycle", err0, 0);
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0a03, 2'b00);
    if (data_ok0) n++;
    check("err_next_cycle", err0, 1);
    check("err_rdata3", srdata0, 32'h0000_0a03);
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
    check("err_sticky", err0, 1);
    check("err_data_ok_count", n, 3);

    // Reset while an AR is pending
    drive0(1'b1, 32'h1c00_0600, 1'b0, 1'b0, 32'h0, 2'b00);
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
    check("pre_reset_arvalid", arvalid0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_reset_err", err0, 0);
    check("mid_reset_cnt", dut0.cnt, 0);
    check("mid_reset_arvalid", arvalid0, 0);
    @(negedge clk);
    reset = 1'b0;

    // R_REG=1: back-to-back beats
    drive1(1'b1, 32'h1c00_0700, 1'b1, 1'b0, 32'h0);
    drive1(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive1(1'b1, 32'h1c00_0704, 1'b1, 1'b0, 32'h0);
    drive1(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive1(1'b0, 32'h0, 1'b0, 1'b1, 32'haaaa_0000);
    check("rreg_hs1_data_ok", data_ok1, 0);
    check("rreg_hs1_rready", rready1, 1);
    drive1(1'b0, 32'h0, 1'b0, 1'b1, 32'hbbbb_0000);
    check("rreg_d1_data_ok", data_ok1, 1);
    check("rreg_d1_rdata", srdata1, 32'haaaa_0000);
    check("rreg_hs2_rready", rready1, 1);
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rreg_d2_data_ok", data_ok1, 1);
    check("rreg_d2_rdata", srdata1, 32'hbbbb_0000);
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rreg_idle_data_ok", data_ok1, 0);
    check("rreg_cnt", dut1.cnt, 0);
    check("rreg_rready", rready1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
